branch_resolve_check: RTL and testbench

- Downstream companion of the hybrid branch predictor.
- Records every fetch-stage prediction (taken flag and target) in order, then checks each one against the MEM-stage resolution of the same branch.
- On a mismatch it raises a one-cycle FLUSH and supplies the corrected fetch PC.
- The FLUSH drives the predictor's and the pipeline's FLUSH inputs.

---
 rtl/branch_resolve_check_pkg.sv | 20 ++
 rtl/branch_resolve_check_fifo.sv | 61 ++++++
 rtl/branch_resolve_check.sv | 134 +++++++++++++
 tb/tb_branch_resolve_check.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_check_pkg.sv
// Shared types for the branch resolution checker: tracked prediction entry and FSM encoding.
package branch_resolve_check_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned PC_W        = 32;

    // Layout of one in-flight prediction; PC_W must equal the top-level ADDR_W.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_entry;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        SQUASH = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/branch_resolve_check_fifo.sv
// pred_fifo: in-order store of fetch-stage predictions with push/pop/clear and occupancy count.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only ever read while count says it is live.
    always_ff @(posedge CLK) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_check.sv
// branch_resolve_check: compares MEM-stage resolutions against recorded predictions and flushes on mismatch.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_check
    import branch_resolve_check_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Pred_valid,
    input  logic [ADDR_W-1:0] Pred_pc,
    input  logic              Pred_taken,
    input  logic [ADDR_W-1:0] Pred_target,
    input  logic              Resolve_valid,
    input  logic [ADDR_W-1:0] Resolve_pc,
    input  logic              Resolve_taken,
    input  logic [ADDR_W-1:0] Resolve_target,
    output logic              FLUSH,
    output logic [ADDR_W-1:0] Redirect_addr,
    output logic              Stall_fetch,
    output logic              Ordering_error,
    output logic [CNT_W-1:0]  Branch_count,
    output logic [CNT_W-1:0]  Mispredict_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fsm_state_e state;
    pred_entry  wr_entry;
    pred_entry  head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW-1:0] fifo_count;

    logic active, resolve, pc_mis, mispredict, pop, push, drop;
    logic [ADDR_W-1:0] redirect_next;

    assign active  = (state != SQUASH);
    assign resolve = active & Resolve_valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_mis     = 1'b0;
        mispredict = 1'b0;
        if (resolve) begin
            if (fifo_empty) begin
                mispredict = 1'b1;
            end else begin
                pc_mis     = (head.pc != Resolve_pc);
                mispredict = (head.taken != Resolve_taken)
                           | (head.taken & Resolve_taken & (head.target != Resolve_target))
                           | pc_mis;
            end
        end
    end

    assign pop  = resolve & ~fifo_empty;
    // A push alongside a mispredicting pop is wrong-path and discarded.
    assign push = active & Pred_valid & (~fifo_full | pop) & ~mispredict;
    assign drop = active & Pred_valid & fifo_full & ~pop;

    assign redirect_next = Resolve_taken ? Resolve_target
                                         : Resolve_pc + ADDR_W'(INSTR_BYTES);

    assign wr_entry = '{pc: Pred_pc, taken: Pred_taken, target: Pred_target};

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pred_entry))
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (push),
        .pop     (pop),
        .clear   (mispredict),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= EMPTY;
            Redirect_addr  <= '0;
            Ordering_error <= 1'b0;
        end else begin
            if (mispredict)
                Redirect_addr <= redirect_next;
            if ((resolve & fifo_empty) | pc_mis | drop)
                Ordering_error <= 1'b1;

            if (mispredict)
                state <= SQUASH;
            else if (state == SQUASH)
                state <= EMPTY;
            else if (push)
                state <= TRACK;
            else if (pop && fifo_count == CW'(1))
                state <= EMPTY;
        end
    end

    // SQUASH lasts exactly one cycle, so it doubles as the registered flush pulse.
    assign FLUSH       = (state == SQUASH);
    assign Stall_fetch = fifo_full;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (pop && br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
            if (mispredict && mp_cnt != '1)
                mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    assign Branch_count     = br_cnt;
    assign Mispredict_count = mp_cnt;
`else
    assign Branch_count     = '0;
    assign Mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_check.sv
// Directed bench for branch_resolve_check; a monitor checks each FLUSH pulse against a queue of expected redirects.
module tb_branch_resolve_check;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Pred_valid = 1'b0;
    logic [31:0] Pred_pc = '0;
    logic        Pred_taken = 1'b0;
    logic [31:0] Pred_target = '0;
    logic        Resolve_valid = 1'b0;
    logic [31:0] Resolve_pc = '0;
    logic        Resolve_taken = 1'b0;
    logic [31:0] Resolve_target = '0;
    logic        FLUSH;
    logic [31:0] Redirect_addr;
    logic        Stall_fetch;
    logic        Ordering_error;
    logic [31:0] Branch_count;
    logic [31:0] Mispredict_count;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    branch_resolve_check #(.DEPTH(4), .ADDR_W(32), .CNT_W(32)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Pred_valid       (Pred_valid),
        .Pred_pc          (Pred_pc),
        .Pred_taken       (Pred_taken),
        .Pred_target      (Pred_target),
        .Resolve_valid    (Resolve_valid),
        .Resolve_pc       (Resolve_pc),
        .Resolve_taken    (Resolve_taken),
        .Resolve_target   (Resolve_target),
        .FLUSH            (FLUSH),
        .Redirect_addr    (Redirect_addr),
        .Stall_fetch      (Stall_fetch),
        .Ordering_error   (Ordering_error),
        .Branch_count     (Branch_count),
        .Mispredict_count (Mispredict_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int br, input int mp);
        check({tag, "_branch_count"}, Branch_count, STATS ? 64'(br) : 64'd0);
        check({tag, "_mispredict_count"}, Mispredict_count, STATS ? 64'(mp) : 64'd0);
    endtask

    // Drive one cycle of stimulus, then return inputs to idle 1 ns after the edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                        input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtg);
        Pred_valid = pv;  Pred_pc = ppc;  Pred_taken = pt;  Pred_target = ptg;
        Resolve_valid = rv; Resolve_pc = rpc; Resolve_taken = rt; Resolve_target = rtg;
        @(posedge CLK); #1;
        Pred_valid = 1'b0; Resolve_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b1, pc, t, tg, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b0, '0, 1'b0, '0, 1'b1, pc, t, tg);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    // Monitor: every FLUSH cycle must consume exactly one expected redirect.
    always @(negedge CLK) begin
        if (RESET && FLUSH) begin
            if (exp_q.size() == 0)
                check("unexpected_flush", FLUSH, 64'd0);
            else
                check("redirect_addr", Redirect_addr, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge CLK); #1;
        check("reset_flush", FLUSH, 0);
        check("reset_redirect", Redirect_addr, 0);
        check("reset_stall", Stall_fetch, 0);
        check("reset_order", Ordering_error, 0);
        check_stats("reset", 0, 0);
        do_reset();

        // Correct taken prediction: no flush.
        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 32'h200);
        idle();
        check_stats("hit", 1, 0);
        check("hit_order", Ordering_error, 0);

        // Direction mispredict: redirect to actual target, one-cycle flush.
        push(32'h100, 1'b0, 32'h0);
        exp_q.push_back(32'h180);
        resolve(32'h100, 1'b1, 32'h180);
        check("dir_flush_now", FLUSH, 1);
        idle();
        check("dir_flush_gone", FLUSH, 0);
        check_stats("dir", 2, 1);

        // Target mispredict flushes the younger entry too.
        push(32'h100, 1'b1, 32'h200);
        push(32'h104, 1'b1, 32'h300);
        exp_q.push_back(32'h204);
        resolve(32'h100, 1'b1, 32'h204);
        idle();
        check_stats("tgt", 3, 2);
        check("tgt_order", Ordering_error, 0);
        exp_q.push_back(32'h300);
        resolve(32'h104, 1'b1, 32'h300);
        idle();
        check("stale_order", Ordering_error, 1);
        check_stats("stale", 3, 3);

        // Fill, overflow drop, push+pop at full, then drain (pointers wrap).
        do_reset();
        push(32'h10, 1'b0, 32'h0);
        push(32'h14, 1'b0, 32'h0);
        push(32'h18, 1'b0, 32'h0);
        check("three_stall", Stall_fetch, 0);
        push(32'h1c, 1'b0, 32'h0);
        check("full_stall", Stall_fetch, 1);
        check("full_order", Ordering_error, 0);
        push(32'h20, 1'b0, 32'h0);
        check("drop_order", Ordering_error, 1);
        check("drop_stall", Stall_fetch, 1);
        step(1'b1, 32'h24, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        check("pushpop_stall", Stall_fetch, 1);
        resolve(32'h14, 1'b0, 32'h0);
        check("drain_stall", Stall_fetch, 0);
        resolve(32'h18, 1'b0, 32'h0);
        resolve(32'h1c, 1'b0, 32'h0);
        resolve(32'h24, 1'b0, 32'h0);
        idle();
        check_stats("drain", 5, 0);

        // Resolve on empty FIFO.
        do_reset();
        exp_q.push_back(32'h204);
        resolve(32'h200, 1'b0, 32'h0);
        idle();
        check("empty_order", Ordering_error, 1);
        check_stats("empty", 0, 1);

        // Head PC mismatch.
        do_reset();
        push(32'h60, 1'b0, 32'h0);
        exp_q.push_back(32'h68);
        resolve(32'h64, 1'b0, 32'h0);
        idle();
        check("pcmis_order", Ordering_error, 1);
        check_stats("pcmis", 1, 1);

        // Reset mid-TRACK with a mispredict pending.
        do_reset();
        push(32'h40, 1'b1, 32'h80);
        push(32'h44, 1'b0, 32'h0);
        push(32'h48, 1'b0, 32'h0);
        Resolve_valid = 1'b1; Resolve_pc = 32'h40; Resolve_taken = 1'b0;
        #1 RESET = 1'b0;
        #1;
        check("rst_flush", FLUSH, 0);
        check("rst_redirect", Redirect_addr, 0);
        check("rst_stall", Stall_fetch, 0);
        check("rst_order", Ordering_error, 0);
        check_stats("rst", 0, 0);
        Resolve_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        idle();
        idle();
        check("rst_after_flush", FLUSH, 0);
        exp_q.push_back(32'h48);
        resolve(32'h44, 1'b0, 32'h0);
        idle();
        check("rst_cleared_order", Ordering_error, 1);

        idle();
        check("pending_flushes", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
